// File: rtl/display_sequencer_pkg.sv
// Shared constants for the display sequencer: FSM state encodings, mode width
// and the wrapping mode-step helper.
package display_sequencer_pkg;

  localparam int MODE_W = 3;

  localparam logic [1:0] ST_MANUAL = 2'b00;
  localparam logic [1:0] ST_AUTO   = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;

  typedef logic [MODE_W-1:0] mode_t;

  // Step mode by +1 (up=1) or -1 (up=0), wrapping inside 0..num-1.
  function automatic mode_t mode_step(input mode_t m, input logic up, input int unsigned num);
    mode_t last;
    last = mode_t'(num - 1);
    if (up) return (m == last) ? '0 : mode_t'(m + 1'b1);
    else    return (m == '0) ? last : mode_t'(m - 1'b1);
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Button/switch inputs and mode/state outputs of the display sequencer.
interface display_sequencer_if;
  import display_sequencer_pkg::*;

  logic       btn_next;
  logic       btn_prev;
  logic       auto_sw;
  logic       hold_sw;
  mode_t      mode;
  logic       mode_chg;
  logic [1:0] state;

  modport master (
    output btn_next, btn_prev, auto_sw, hold_sw,
    input  mode, mode_chg, state
  );

  modport slave (
    input  btn_next, btn_prev, auto_sw, hold_sw,
    output mode, mode_chg, state
  );
endinterface

// File: rtl/display_sequencer_button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter and a one-cycle
// press pulse on the rising edge of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CNT = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic             meta_reg;
  logic             sync_reg;
  logic             level_reg;
  logic             level_d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             armed_reg;
  logic [CNT_W-1:0] arm_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg    <= 1'b0;
      sync_reg    <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      cnt_reg     <= '0;
      armed_reg   <= 1'b0;
      arm_cnt_reg <= '0;
    end else begin
      meta_reg    <= btn;
      sync_reg    <= meta_reg;
      level_d_reg <= level_reg;
      if (sync_reg != level_reg) begin
        if (cnt_reg == CNT_W'(DEBOUNCE_CNT - 1)) begin
          level_reg <= sync_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
      // A button held through reset must be seen released for a full
      // debounce interval before its next rise counts as a press.
      if (!armed_reg) begin
        if (sync_reg)
          arm_cnt_reg <= '0;
        else if (arm_cnt_reg == CNT_W'(DEBOUNCE_CNT - 1))
          armed_reg <= 1'b1;
        else
          arm_cnt_reg <= arm_cnt_reg + 1'b1;
      end
    end
  end

  assign press = level_reg & ~level_d_reg & armed_reg;

endmodule

// File: rtl/display_sequencer.sv
// Display-source sequencer: debounced next/prev buttons, hold switch and an
// optional auto-scroll mode enabled by DISPLAY_SEQUENCER_AUTO_EN.
module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter int NUM_MODES    = 7,
  parameter int DEBOUNCE_CNT = 250000,
  parameter int SCROLL_CNT   = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  display_sequencer_if.slave bus
);
  logic       next_ev;
  logic       prev_ev;
  logic       btn_ev;
  logic       scroll_hit;
  logic       hold_meta_reg;
  logic       hold_sync_reg;
  logic [1:0] state_reg;
  logic [1:0] state_next;
  mode_t      mode_reg;
  mode_t      mode_next;
  logic       mode_upd;
  logic       mode_chg_reg;

  button_debouncer #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_next_db (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_next), .press(next_ev)
  );

  button_debouncer #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_prev_db (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_prev), .press(prev_ev)
  );

  // Opposing presses in the same cycle cancel out.
  assign btn_ev = next_ev ^ prev_ev;

`ifdef DISPLAY_SEQUENCER_AUTO_EN
  localparam int SCROLL_W = $clog2(SCROLL_CNT + 1);

  logic                auto_meta_reg;
  logic                auto_sync_reg;
  logic [SCROLL_W-1:0] scroll_cnt_reg;

  assign scroll_hit = (state_reg == ST_AUTO) && (scroll_cnt_reg == SCROLL_W'(SCROLL_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_meta_reg  <= 1'b0;
      auto_sync_reg  <= 1'b0;
      scroll_cnt_reg <= '0;
    end else begin
      auto_meta_reg <= bus.auto_sw;
      auto_sync_reg <= auto_meta_reg;
      if ((state_reg != ST_AUTO) || btn_ev || scroll_hit)
        scroll_cnt_reg <= '0;
      else
        scroll_cnt_reg <= scroll_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = ST_MANUAL;
    if (hold_sync_reg)      state_next = ST_HOLD;
    else if (auto_sync_reg) state_next = ST_AUTO;
  end
`else
  assign scroll_hit = 1'b0;

  always_comb begin
    state_next = ST_MANUAL;
    if (hold_sync_reg) state_next = ST_HOLD;
  end
`endif

  always_comb begin
    mode_next = mode_reg;
    mode_upd  = 1'b0;
    if (state_reg != ST_HOLD) begin
      if (btn_ev) begin
        mode_next = mode_step(mode_reg, next_ev, NUM_MODES);
        mode_upd  = 1'b1;
      end else if (scroll_hit) begin
        mode_next = mode_step(mode_reg, 1'b1, NUM_MODES);
        mode_upd  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_meta_reg <= 1'b0;
      hold_sync_reg <= 1'b0;
      state_reg     <= ST_MANUAL;
      mode_reg      <= '0;
      mode_chg_reg  <= 1'b0;
    end else begin
      hold_meta_reg <= bus.hold_sw;
      hold_sync_reg <= hold_meta_reg;
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      mode_chg_reg  <= mode_upd;
    end
  end

  assign bus.mode     = mode_reg;
  assign bus.mode_chg = mode_chg_reg;
  assign bus.state    = state_reg;

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 Parameter: NUM_MODES, 7, number of selectable display sources; mode values run 0..NUM_MODES-1.
REQ-002 Parameter: DEBOUNCE_CNT, 250000, consecutive stable cycles needed to accept a button level change.
REQ-003 Parameter: SCROLL_CNT, 50000000, cycles per automatic mode advance.
REQ-004 Port: clk  input  1  single clock for all state.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: btn_next  input  1  raw, asynchronous push-button that advances mode.
REQ-007 Port: btn_prev  input  1  raw, asynchronous push-button that retreats mode.
REQ-008 Port: auto_sw  input  1  level switch requesting auto-scroll; synchronized, not debounced.
REQ-009 Port: hold_sw  input  1  level switch freezing mode; synchronized, not debounced.
REQ-010 Port: mode  output  3  registered display-source select driving the display mux.
REQ-011 Port: mode_chg  output  1  registered one-cycle pulse, high in the first cycle a new mode value is visible.
REQ-012 Port: state  output  2  registered FSM state: 00 MANUAL, 01 AUTO, 10 HOLD.

Function
REQ-013 Each button passes through a 2-FF synchronizer, then a debouncer; the debounced level toggles only after the synchronized level differs from it for DEBOUNCE_CNT consecutive cycles; any reversion clears the counter.
REQ-014 A press event is a one-cycle pulse on the rising edge of the debounced level; release generates no event.
REQ-015 Press latency: mode updates DEBOUNCE_CNT+3 cycles after a clean raw rising edge (2 sync + count + edge register).
REQ-016 FSM priority, evaluated every cycle: hold_sync=1 -> HOLD; else auto_sync=1 -> AUTO; else MANUAL.
REQ-017 MANUAL: next event -> mode+1, wrapping NUM_MODES-1 -> 0; prev event -> mode-1, wrapping 0 -> NUM_MODES-1.
REQ-018 Simultaneous next and prev events in the same cycle are ignored; mode is unchanged and mode_chg stays low.
REQ-019 AUTO: a scroll counter advances mode by +1 (with wrap) each SCROLL_CNT cycles; next/prev events also apply and restart the scroll counter.
REQ-020 Scroll counter clears on every entry to AUTO, so the first auto advance occurs SCROLL_CNT cycles after entry.
REQ-021 HOLD: mode frozen; button events and the scroll counter are discarded, not queued.
REQ-022 mode never holds a value >= NUM_MODES.
REQ-023 mode_chg pulses exactly once per mode update; it does not pulse on state changes alone.

Reset
REQ-024 While rst_n=0: mode=0, mode_chg=0, state=MANUAL, synchronizers, debounced levels, debounce counters and the scroll counter all 0.
REQ-025 Reset asserted mid-debounce or mid-scroll discards the partial count; no event is generated on release of reset, even with a button held.

Configuration
REQ-026 Macro DISPLAY_SEQUENCER_AUTO_EN: when defined, AUTO state and scroll counter are built per REQ-019/020.
REQ-027 Without DISPLAY_SEQUENCER_AUTO_EN: auto_sw is ignored, the scroll counter is absent, state never equals 01, and the FSM moves only between MANUAL and HOLD.

Structure
REQ-028 Shared package holds the state encoding constants (MANUAL, AUTO, HOLD) and the mode width constant (3).
REQ-029 One sub-module, button_debouncer (synchronizer + debounce counter + rising-edge pulse), is instantiated twice.

Verification (DEBOUNCE_CNT=4, SCROLL_CNT=8, NUM_MODES=7)
REQ-030 Reset, then a clean btn_next press held 20 cycles -> mode 0->1 exactly 7 cycles after the edge, one mode_chg pulse, no further change while held.
REQ-031 btn_next glitch high for 3 cycles -> no mode change; at mode=6, next press -> mode=0; at mode=0, prev press -> mode=6.
REQ-032 btn_next and btn_prev rise in the same cycle -> mode unchanged, mode_chg never asserted.
REQ-033 auto_sw=1 for 30 cycles from mode=5 -> mode 6, 0, 1 at 8-cycle intervals after entry; state=01 throughout (macro defined); same stimulus without the macro -> mode stays 5, state=00.
REQ-034 hold_sw=1 with auto_sw=1 and button presses -> state=10, mode frozen; hold_sw dropped -> state=01 and the first advance occurs 8 cycles later.
REQ-035 rst_n pulsed low mid-debounce with btn_next held -> all outputs 0 immediately; no event after reset release until the button is released and pressed again.
